// File: rtl/alu_issue_queue.sv
// ============================================================================
//  Module      : alu_issue_queue
//  Description : Command FIFO, registered ALU issue slot and registered result
//                slot with result chaining for the 32-bit ALU datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_queue #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [OP_W-1:0]          in_op,
    input  logic                     in_chain,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [OP_W-1:0]          alu_op,
    input  logic [DATA_W-1:0]        alu_y,
    input  logic                     alu_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_y,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam int              c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    logic [DATA_W-1:0] r_mem_a     [DEPTH];
    logic [DATA_W-1:0] r_mem_b     [DEPTH];
    logic [OP_W-1:0]   r_mem_op    [DEPTH];
    logic              r_mem_chain [DEPTH];

    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic              r_issue_valid;
    logic [DATA_W-1:0] r_issue_a;
    logic [DATA_W-1:0] r_issue_b;
    logic [OP_W-1:0]   r_issue_op;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_y;
    logic              r_out_carry;
    logic [DATA_W-1:0] r_last_y;

    logic              w_full;
    logic              w_push;
    logic              w_cap;
    logic              w_pop;
    logic [DATA_W-1:0] w_prev_y;

    assign w_full = (r_count == c_FULL);
    assign w_push = in_valid && !w_full;
    assign w_cap  = r_issue_valid && (!r_out_valid || out_ready);
    assign w_pop  = (r_count != '0) && (!r_issue_valid || w_cap);

    // Result that precedes the command being popped: the one captured this edge, if any.
    assign w_prev_y = w_cap ? alu_y : r_last_y;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]     <= in_a;
            r_mem_b[r_wr_ptr]     <= in_b;
            r_mem_op[r_wr_ptr]    <= in_op;
            r_mem_chain[r_wr_ptr] <= in_chain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_issue_valid <= 1'b0;
            r_issue_a     <= '0;
            r_issue_b     <= '0;
            r_issue_op    <= '0;
            r_out_valid   <= 1'b0;
            r_out_y       <= '0;
            r_out_carry   <= 1'b0;
            r_last_y      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end

            // Chained operand is resolved on entry so alu_a stays stable while the slot holds.
            if (w_pop) begin
                r_issue_valid <= 1'b1;
                r_issue_a     <= r_mem_chain[r_rd_ptr] ? w_prev_y : r_mem_a[r_rd_ptr];
                r_issue_b     <= r_mem_b[r_rd_ptr];
                r_issue_op    <= r_mem_op[r_rd_ptr];
            end else if (w_cap) begin
                r_issue_valid <= 1'b0;
            end

            if (w_cap) begin
                r_out_valid <= 1'b1;
                r_out_y     <= alu_y;
                r_out_carry <= alu_carry;
                r_last_y    <= alu_y;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = !w_full;
    assign alu_a     = r_issue_a;
    assign alu_b     = r_issue_b;
    assign alu_op    = r_issue_op;
    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_carry = r_out_carry;
    assign out_zero  = (r_out_y == '0);
    assign count     = r_count;
    assign busy      = (r_count != '0) || r_issue_valid || r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// ============================================================================
//  Module      : tb_alu_issue_queue
//  Description : Directed scoreboard bench for alu_issue_queue with an ALU model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_queue;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int DEPTH  = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_a;
    logic [DATA_W-1:0]      in_b;
    logic [OP_W-1:0]        in_op;
    logic                   in_chain;
    logic [DATA_W-1:0]      alu_a;
    logic [DATA_W-1:0]      alu_b;
    logic [OP_W-1:0]        alu_op;
    logic [DATA_W-1:0]      alu_y;
    logic                   alu_carry;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_y;
    logic                   out_carry;
    logic                   out_zero;
    logic [$clog2(DEPTH):0] count;
    logic                   busy;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_out   = 0;
    int stalls  = 0;
    int max_cnt = 0;

    logic [DATA_W:0]   sb_q[$];
    logic [DATA_W-1:0] model_last;

    alu_issue_queue #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_carry(out_carry), .out_zero(out_zero),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model: op 1 subtracts, anything else adds; bit DATA_W is the carry.
    function automatic logic [DATA_W:0] alu_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                              input logic [OP_W-1:0] op);
        if (op == OP_W'(1)) return {1'b0, a} - {1'b0, b};
        return {1'b0, a} + {1'b0, b};
    endfunction

    always_comb begin
        {alu_carry, alu_y} = alu_f(alu_a, alu_b, alu_op);
    end

    task automatic chk(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && int'(count) > max_cnt) max_cnt = int'(count);
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_result observed=0x%0h expected=none", out_y);
            end else begin
                logic [DATA_W:0] e;
                e = sb_q.pop_front();
                chk("out_y", out_y, e[DATA_W-1:0]);
                chk("out_carry", out_carry, e[DATA_W]);
                chk("out_zero", out_zero, e[DATA_W-1:0] == '0);
                n_out++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [OP_W-1:0] op, input logic ch);
        int w;
        logic [DATA_W-1:0] ae;
        logic [DATA_W:0]   r;
        w = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_chain = ch;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("push_timeout", in_ready, 1);
        end else begin
            if (w > 0) stalls++;
            ae = ch ? model_last : a;
            r  = alu_f(ae, b, op);
            model_last = r[DATA_W-1:0];
            sb_q.push_back(r);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_busy", busy, 0);
        chk("idle_sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_chain = 1'b0;
        out_ready = 1'b0; model_last = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_a", alu_a, 0);

        // Single command latency
        out_ready = 1'b1;
        push(32'd5, 32'd3, 4'd0, 1'b0);
        chk("lat_count_after_push", count, 1);
        chk("lat_valid_e0", out_valid, 0);
        tick();
        chk("lat_valid_e1", out_valid, 0);
        tick();
        chk("lat_valid_e2", out_valid, 1);
        chk("lat_out_y", out_y, 8);
        chk("lat_carry", out_carry, 0);
        chk("lat_zero", out_zero, 0);
        tick();
        chk("lat_drained_valid", out_valid, 0);
        chk("lat_drained_count", count, 0);
        chk("lat_drained_busy", busy, 0);

        // Streaming at full rate
        stalls = 0; max_cnt = 0; n_out = 0;
        for (int i = 0; i < 6; i++) push(DATA_W'(i * 10), DATA_W'(i + 1), 4'd0, 1'b0);
        wait_idle();
        chk("stream_stalls", stalls, 0);
        chk("stream_max_count_le1", max_cnt <= 1, 1);
        chk("stream_n_out", n_out, 6);

        // Backpressure to full then release
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(DATA_W'(100 + i), DATA_W'(i), 4'd0, 1'b0);
        chk("bp_count_full", count, DEPTH);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        repeat (3) tick();
        chk("bp_out_y_held", out_y, 100);
        chk("bp_count_held", count, DEPTH);
        out_ready = 1'b1;
        chk("bp_in_ready_before_pop", in_ready, 0);
        tick();
        chk("bp_in_ready_after_pop", in_ready, 1);
        chk("bp_count_after_pop", count, DEPTH - 1);
        wait_idle();

        // Push coinciding with pop at DEPTH-1, then rejected push at DEPTH
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(DATA_W'(200 + i), DATA_W'(i), 4'd0, 1'b0);
        chk("edge_count_pre", count, DEPTH - 1);
        out_ready = 1'b1;
        push(32'd300, 32'd1, 4'd0, 1'b0);
        out_ready = 1'b0;
        chk("edge_count_push_pop", count, DEPTH - 1);
        push(32'd400, 32'd2, 4'd0, 1'b0);
        chk("edge_count_full", count, DEPTH);
        in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1; in_op = 4'd0; in_chain = 1'b0;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("edge_reject_count", count, DEPTH);
        chk("edge_reject_ready", in_ready, 0);
        out_ready = 1'b1;
        wait_idle();

        // Chaining back-to-back, plus an opcode pass-through
        push(32'hFFFF_FFFF, 32'd1, 4'd0, 1'b0);
        push(32'h0, 32'd7, 4'd0, 1'b1);
        push(32'h0, 32'd2, 4'd0, 1'b1);
        push(32'd20, 32'd5, 4'd1, 1'b0);
        wait_idle();

        // Reset with work in flight
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(DATA_W'(i), DATA_W'(i), 4'd0, 1'b0);
        chk("mid_out_valid", out_valid, 1);
        chk("mid_count", count, 3);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        rst = 1'b0;
        sb_q.delete();
        model_last = '0;
        out_ready = 1'b1;
        push(32'h1234, 32'd4, 4'd0, 1'b1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
